// File: rtl/button_event_scheduler_pkg.sv
// Shared event-type codes, arbiter state encoding and the press>long>repeat>release priority picker.
package button_event_pkg;
  localparam int EVT_W   = 2;
  localparam int NUM_EVT = 4;

  localparam logic [EVT_W-1:0] EVT_PRESS   = 2'b00;
  localparam logic [EVT_W-1:0] EVT_RELEASE = 2'b01;
  localparam logic [EVT_W-1:0] EVT_LONG    = 2'b10;
  localparam logic [EVT_W-1:0] EVT_REPEAT  = 2'b11;

  typedef enum logic {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} arb_state_e;

  function automatic logic [EVT_W-1:0] pick_type(input logic [NUM_EVT-1:0] p);
    if (p[EVT_PRESS])  return EVT_PRESS;
    if (p[EVT_LONG])   return EVT_LONG;
    if (p[EVT_REPEAT]) return EVT_REPEAT;
    return EVT_RELEASE;
  endfunction
endpackage

// File: rtl/button_event_scheduler_if.sv
// Valid/ready event port: the scheduler is the master, the menu FSM the slave.
interface button_event_scheduler_if #(parameter int ID_W = 2);
  import button_event_pkg::*;
  logic             EventValid;
  logic             EventReady;
  logic [ID_W-1:0]  EventId;
  logic [EVT_W-1:0] EventType;

  modport master (output EventValid, EventId, EventType, input EventReady);
  modport slave  (input EventValid, EventId, EventType, output EventReady);
endinterface

// File: rtl/button_event_scheduler_channel.sv
// One button: 2-flop sync, tick-based debounce, hold/long detection and post strobes.
// Auto-repeat counter is present only when BUTTON_AUTO_REPEAT_EN is defined.
module button_channel
  import button_event_pkg::*;
#(
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               noisy_i,
  output logic               clean_o,
  output logic [NUM_EVT-1:0] post_o
);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  logic          s1_q, s2_q, clean_q, clean_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rise, fall, long_hit;

  always_comb begin
    clean_d  = clean_q;
    stab_d   = stab_q;
    hold_d   = hold_q;
    rise     = 1'b0;
    fall     = 1'b0;
    long_hit = 1'b0;
    if (tick_i) begin
      if (s2_q != clean_q) begin
        if (stab_q == SW'(STABLE_TICKS - 1)) begin
          clean_d = s2_q;
          stab_d  = '0;
          rise    = s2_q;
          fall    = ~s2_q;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end else begin
        stab_d = '0;
      end
    end
    // Saturates at LONG_TICKS so the long event fires exactly once per hold.
    if (!clean_q) begin
      hold_d = '0;
    end else if (tick_i && hold_q != HW'(LONG_TICKS)) begin
      hold_d   = hold_q + 1'b1;
      long_hit = (hold_q == HW'(LONG_TICKS - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      stab_q  <= '0;
      hold_q  <= '0;
    end else begin
      s1_q    <= noisy_i;
      s2_q    <= s1_q;
      clean_q <= clean_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
    end
  end

  assign clean_o               = clean_q;
  assign post_o[EVT_PRESS]     = rise;
  assign post_o[EVT_RELEASE]   = fall;
  assign post_o[EVT_LONG]      = long_hit;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic          rep_hit;

  always_comb begin
    rep_d   = rep_q;
    rep_hit = 1'b0;
    if (!clean_q) begin
      rep_d = '0;
    end else if (tick_i && hold_q == HW'(LONG_TICKS)) begin
      if (rep_q == RW'(REPEAT_TICKS - 1)) begin
        rep_d   = '0;
        rep_hit = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end

  assign post_o[EVT_REPEAT] = rep_hit;
`else
  assign post_o[EVT_REPEAT] = 1'b0;
`endif
endmodule

// File: rtl/button_event_scheduler.sv
// Keypad front end: shared tick prescaler, per-button channels, pending store and
// round-robin arbiter onto one valid/ready port. Optional: BUTTON_AUTO_REPEAT_EN.
module button_event_scheduler
  import button_event_pkg::*;
#(
  parameter int NUM_BUTTONS  = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_BUTTONS-1:0] NoisyButtonsIn,
  output logic [NUM_BUTTONS-1:0] CleanButtonsOut,
  output logic                   Overflow,
  input  logic                   ClearOverflow,
  button_event_scheduler_if.master evt
);
  localparam int ID_W = $clog2(NUM_BUTTONS);
  localparam int DW   = $clog2(TICK_DIV + 1);

  logic [DW-1:0] div_q;
  logic          tick;
  logic [NUM_BUTTONS-1:0][NUM_EVT-1:0] post, pend_q, pend_d, clr;
  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d, ptr_q, ptr_d, idx;
  logic [EVT_W-1:0] type_q, type_d;
  logic             found, ovf_q, ovf_new;

  assign tick = (div_q == DW'(TICK_DIV - 1));

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    button_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk     (CLK),
      .rst_n   (RST_N),
      .tick_i  (tick),
      .noisy_i (NoisyButtonsIn[g]),
      .clean_o (CleanButtonsOut[g]),
      .post_o  (post[g])
    );
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    type_d  = type_q;
    ptr_d   = ptr_q;
    clr     = '0;
    found   = 1'b0;
    idx     = '0;
    case (state_q)
      ST_IDLE: begin
        for (int k = 0; k < NUM_BUTTONS; k++) begin
          idx = ID_W'((int'(ptr_q) + k) % NUM_BUTTONS);
          if (!found && |pend_q[idx]) begin
            found   = 1'b1;
            id_d    = idx;
            type_d  = pick_type(pend_q[idx]);
            state_d = ST_PRESENT;
          end
        end
      end
      ST_PRESENT: begin
        if (evt.EventReady) begin
          clr[id_q][type_q] = 1'b1;
          ptr_d   = (id_q == ID_W'(NUM_BUTTONS - 1)) ? '0 : id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A post landing on a bit being consumed this cycle re-arms it without counting as overflow.
  assign pend_d  = (pend_q & ~clr) | post;
  assign ovf_new = |(post & pend_q & ~clr);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q   <= '0;
      pend_q  <= '0;
      state_q <= ST_IDLE;
      id_q    <= '0;
      type_q  <= EVT_PRESS;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      div_q   <= tick ? '0 : div_q + 1'b1;
      pend_q  <= pend_d;
      state_q <= state_d;
      id_q    <= id_d;
      type_q  <= type_d;
      ptr_q   <= ptr_d;
      ovf_q   <= (ovf_q & ~ClearOverflow) | ovf_new;
    end
  end

  assign evt.EventValid = (state_q == ST_PRESENT);
  assign evt.EventId    = id_q;
  assign evt.EventType  = type_q;
  assign Overflow       = ovf_q;
endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
Front-end controller for the terminal keypad. It debounces NUM_BUTTONS raw buttons with one shared sample-tick prescaler and per-button stability counters. It classifies each button's activity into press, release and long-press events, then arbitrates the pending events round-robin onto one valid/ready event port. The port is consumed by the sale-terminal menu FSM.

Parameters:
NUM_BUTTONS, 4, number of button inputs (>=2)
TICK_DIV, 50000, CLK cycles per sample tick (1 ms at 50 MHz)
STABLE_TICKS, 10, consecutive disagreeing ticks needed to accept a new level (>=1)
LONG_TICKS, 1000, ticks a button must stay pressed before a long event
REPEAT_TICKS, 200, auto-repeat period in ticks (used only with AUTO_REPEAT_EN)

Ports:
CLK  input  1  clock; the block's only clock
RST_N  input  1  reset; asynchronous, active-low; clears all state
NoisyButtonsIn  input  NUM_BUTTONS  raw buttons, 1 = pressed, asynchronous to CLK
CleanButtonsOut  output  NUM_BUTTONS  debounced levels
EventValid  output  1  event available
EventReady  input  1  consumer accepts event
EventId  output  $clog2(NUM_BUTTONS)  button index of the event
EventType  output  2  event type: 00 press, 01 release, 10 long, 11 repeat
Overflow  output  1  sticky; set when an event is merged into an already-pending one
ClearOverflow  input  1  synchronous clear of Overflow

Behaviour:
- Reset values: all outputs 0. Synchronizers, counters, pending bits, round-robin pointer and FSM (IDLE) are all cleared.
- Synchronizer: 2-flop per button. Samples taken from the second flop.
- Prescaler: counts 0..TICK_DIV-1 and wraps. Tick is a 1-cycle pulse on terminal count.
- Debounce, per button, evaluated on Tick only:
  - sync != Clean: StableCnt++. When STABLE_TICKS consecutive ticks have disagreed, Clean <= sync, StableCnt <= 0, and a press event (0->1) or release event (1->0) is posted.
  - sync == Clean: StableCnt <= 0.
  - A one-tick glitch therefore never propagates.
- Hold counter, per button:
  - On Tick with Clean = 1: HoldCnt increments, saturating at LONG_TICKS.
  - The transition to LONG_TICKS posts a long event exactly once.
  - Clean = 0 clears HoldCnt.
- Pending store: one bit per (button, type).
  - Posting sets the bit. Posting to an already-set bit sets Overflow; events merge, no queue.
  - Post and consume of the same bit in the same cycle: bit stays set, no overflow.
- Arbiter FSM:
  - IDLE: if any pending bit is set, select a button round-robin, searching from the pointer upward and wrapping. Within that button the type priority is press > long > repeat > release. Latch Id/Type and go to PRESENT.
  - PRESENT: EventValid = 1, with Id/Type held stable until accepted. On EventReady = 1: clear that pending bit, set pointer = (Id+1) mod NUM_BUTTONS, return to IDLE.
  - Max throughput: one event per 2 cycles.
  - EventReady is ignored while in IDLE.
- Overflow: ClearOverflow clears it. A new overflow in the same cycle wins (stays 1).
- Reset assertion mid-operation clears immediately, including a presented event. After reset, a button held during reset produces a press after STABLE_TICKS ticks.
- Counter widths use $clog2(limit+1). There is no wrap inside the debounce and hold counters.

Optional Feature:
BUTTON_AUTO_REPEAT_EN
- Defined: after a button's long event, a per-button RepeatCnt posts a repeat event (type 11) every REPEAT_TICKS ticks while Clean = 1. Release clears RepeatCnt.
- Undefined: RepeatCnt and repeat pending bits are absent, and type 11 is never produced.

Decomposition:
- Package button_event_pkg holds:
  - EVT_PRESS, EVT_RELEASE, EVT_LONG and EVT_REPEAT localparams
  - the event-type width constant
  - FSM state encodings
- Sub-module button_channel: synchronizer, stability counter, hold/repeat counters and post strobes for one button. It takes the shared Tick as input and is instantiated NUM_BUTTONS times.
- The top level holds the prescaler, pending store, arbiter FSM and Overflow.

Test Plan:
All scenarios use TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10, NUM_BUTTONS=4.
- Button0 clean rise, EventReady=1 -> CleanButtonsOut[0] rises on the 3rd tick after the synchronized input changes, followed by exactly one event with Id=0, Type=00.
- Button1 toggling every 5 cycles for 60 cycles, then held high -> no events or Clean change during bouncing; one press after 3 stable ticks.
- Buttons 0-3 rise on the same cycle, EventReady=1 -> press events in order Id 0,1,2,3, EventValid low for one cycle between them.
- Button2 held for 15 ticks then released -> press, long 10 ticks after the Clean rise, then release. With BUTTON_AUTO_REPEAT_EN and REPEAT_TICKS=4, repeats arrive every 4 ticks after the long event.
- EventReady=0, button3 pressed/released twice -> Overflow=1. Draining yields only a press then a release. A ClearOverflow pulse returns Overflow to 0.
- RST_N asserted while EventValid=1 -> EventValid, CleanButtonsOut and Overflow are 0 before the next CLK edge, with no event after release unless a button is held.
